// File: rtl/alu_issue_ctrl.sv
// Issue/response sequencer driving a clocked, one-cycle-latency RV32I ALU.
// Optional perf counters are compiled in with `define ALU_ISSUE_PERF_CNT_EN.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // upstream instruction handshake
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  // ALU drive; alu_ctrl encoding: 00 ADD, 01 SUB, 10 AND, 11 OR
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [1:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_data_out,
  input  logic                  alu_zero,
  // downstream response handshake
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_is_branch,
  output logic                  out_taken,
  output logic                  out_illegal,
`ifdef ALU_ISSUE_PERF_CNT_EN
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_taken,
  output logic [31:0]           perf_illegal,
`endif
  // debug view of the sequencer state: 0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP
  output logic [1:0]            fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Once valid is raised it stays high, with its payload stable,
  // until that transfer; ready may change freely and never depends on valid.

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_AND = 2'b10;
  localparam logic [1:0] CTRL_OR  = 2'b11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       accept;
  logic       handoff;
  logic       is_bne;

  logic       dec_legal;
  logic [1:0] dec_ctrl;
  logic       dec_use_imm;
  logic       dec_branch;
  logic       dec_bne;

  always_comb begin
    dec_legal   = 1'b0;
    dec_ctrl    = CTRL_ADD;
    dec_use_imm = 1'b0;
    dec_branch  = 1'b0;
    dec_bne     = 1'b0;
    case (in_opcode)
      OP_R: begin
        case (in_funct3)
          3'b000: begin
            if (in_funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_ctrl  = CTRL_ADD;
            end else if (in_funct7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_ctrl  = CTRL_SUB;
            end
          end
          3'b111: begin
            dec_legal = (in_funct7 == F7_BASE);
            dec_ctrl  = CTRL_AND;
          end
          3'b110: begin
            dec_legal = (in_funct7 == F7_BASE);
            dec_ctrl  = CTRL_OR;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec_use_imm = 1'b1;
        case (in_funct3)
          3'b000: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_ADD;
          end
          3'b111: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_AND;
          end
          3'b110: begin
            dec_legal = 1'b1;
            dec_ctrl  = CTRL_OR;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        // BEQ/BNE compare by subtraction and read the ALU zero flag
        if (in_funct3 == 3'b000 || in_funct3 == 3'b001) begin
          dec_legal  = 1'b1;
          dec_ctrl   = CTRL_SUB;
          dec_branch = 1'b1;
          dec_bne    = in_funct3[0];
        end
      end
      OP_LOAD, OP_STORE: begin
        dec_legal   = 1'b1;
        dec_ctrl    = CTRL_ADD;
        dec_use_imm = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = dec_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  state_next = S_RESP;
      S_RESP:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs; in_ready is forced low while reset is asserted
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready  = !rst;
      S_RESP:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign fsm_state = state;
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  // Operand and response registers. An illegal accept leaves alu_* untouched
  // so the ALU keeps seeing the previous operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= CTRL_ADD;
      out_result    <= '0;
      out_is_branch <= 1'b0;
      out_taken     <= 1'b0;
      out_illegal   <= 1'b0;
      is_bne        <= 1'b0;
    end else begin
      if (accept) begin
        out_taken <= 1'b0;
        if (dec_legal) begin
          alu_a         <= in_rs1;
          alu_b         <= dec_use_imm ? in_imm : in_rs2;
          alu_ctrl      <= dec_ctrl;
          out_is_branch <= dec_branch;
          is_bne        <= dec_bne;
          out_illegal   <= 1'b0;
        end else begin
          out_is_branch <= 1'b0;
          is_bne        <= 1'b0;
          out_illegal   <= 1'b1;
          out_result    <= '0;
        end
      end
      if (state == S_WAIT) begin
        out_result <= alu_data_out;
        out_taken  <= out_is_branch && (is_bne ? !alu_zero : alu_zero);
      end
    end
  end

`ifdef ALU_ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_taken   <= '0;
      perf_illegal <= '0;
    end else begin
      if (accept && dec_legal)  perf_issued  <= perf_issued + 32'd1;
      if (accept && !dec_legal) perf_illegal <= perf_illegal + 32'd1;
      if (handoff && out_taken) perf_taken   <= perf_taken + 32'd1;
    end
  end
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered one-cycle ALU model.
// Define ALU_ISSUE_PERF_CNT_EN for both files to also check the perf counters.
module tb_alu_issue_ctrl;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_data_out;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_is_branch;
  logic        out_taken;
  logic        out_illegal;
  logic [1:0]  fsm_state;
`ifdef ALU_ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_taken;
  logic [31:0] perf_illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_funct3     (in_funct3),
    .in_funct7     (in_funct7),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_imm        (in_imm),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctrl      (alu_ctrl),
    .alu_data_out  (alu_data_out),
    .alu_zero      (alu_zero),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_is_branch (out_is_branch),
    .out_taken     (out_taken),
    .out_illegal   (out_illegal),
`ifdef ALU_ISSUE_PERF_CNT_EN
    .perf_issued   (perf_issued),
    .perf_taken    (perf_taken),
    .perf_illegal  (perf_illegal),
`endif
    .fsm_state     (fsm_state)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // registered ALU model, one cycle of latency
  logic [31:0] alu_model_res;
  always_comb begin
    case (alu_ctrl)
      ADD:     alu_model_res = alu_a + alu_b;
      SUB:     alu_model_res = alu_a - alu_b;
      AND:     alu_model_res = alu_a & alu_b;
      default: alu_model_res = alu_a | alu_b;
    endcase
  end
  always @(posedge clk) begin
    alu_data_out <= alu_model_res;
    alu_zero     <= (alu_model_res == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // Full legal transaction with out_ready high; starts and ends in IDLE.
  task automatic run_legal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [1:0] exp_ctrl,
                           input logic [31:0] exp_b, input logic [31:0] exp_res,
                           input logic exp_br, input logic exp_taken);
    out_ready = 1'b1;
    set_op(op, f3, f7, rs1, rs2, imm);
    tick();
    in_valid = 1'b0;
    check({tag, " issue state"}, 32'(fsm_state), 32'(ST_ISSUE));
    check({tag, " alu_ctrl"}, 32'(alu_ctrl), 32'(exp_ctrl));
    check({tag, " alu_a"}, alu_a, rs1);
    check({tag, " alu_b"}, alu_b, exp_b);
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    tick();
    check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_result"}, out_result, exp_res);
    check({tag, " out_is_branch"}, 32'(out_is_branch), 32'(exp_br));
    check({tag, " out_taken"}, 32'(out_taken), 32'(exp_taken));
    check({tag, " out_illegal"}, 32'(out_illegal), 32'd0);
    tick();
    check({tag, " back to idle"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_op(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    in_valid  = 1'b0;
    tick();
    tick();

    // reset state
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst alu_ctrl", 32'(alu_ctrl), 32'(ADD));
    check("rst alu_a", alu_a, 32'd0);
    check("rst out_result", out_result, 32'd0);
    check("rst flags", {29'd0, out_is_branch, out_taken, out_illegal}, 32'd0);
    rst = 1'b0;
    #1;
    check("post rst in_ready", 32'(in_ready), 32'd1);

    // main decode paths
    run_legal("add", 7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'hFFFF_FFFD, 32'd0,
              ADD, 32'hFFFF_FFFD, 32'd2, 1'b0, 1'b0);
    run_legal("sub", 7'b0110011, 3'b000, 7'b0100000, 32'h10, 32'h20, 32'd0,
              SUB, 32'h20, 32'hFFFF_FFF0, 1'b0, 1'b0);
    run_legal("ori", 7'b0010011, 3'b110, 7'b1111111, 32'hF0, 32'h123, 32'h0F,
              OR, 32'h0F, 32'hFF, 1'b0, 1'b0);
    run_legal("lw", 7'b0000011, 3'b010, 7'b0000000, 32'h1000, 32'h55, 32'hFFFF_FFFC,
              ADD, 32'hFFFF_FFFC, 32'h0FFC, 1'b0, 1'b0);
    run_legal("beq eq", 7'b1100011, 3'b000, 7'b0000000, 32'd7, 32'd7, 32'd0,
              SUB, 32'd7, 32'd0, 1'b1, 1'b1);
    run_legal("bne eq", 7'b1100011, 3'b001, 7'b0000000, 32'd7, 32'd7, 32'd0,
              SUB, 32'd7, 32'd0, 1'b1, 1'b0);
    run_legal("bne ne", 7'b1100011, 3'b001, 7'b0000000, 32'd7, 32'd8, 32'd0,
              SUB, 32'd8, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // illegal SLL: response one cycle after accept, ALU drive unchanged
    set_op(7'b0110011, 3'b001, 7'b0000000, 32'hAA, 32'hBB, 32'd0);
    tick();
    in_valid = 1'b0;
    check("sll out_valid", 32'(out_valid), 32'd1);
    check("sll out_illegal", 32'(out_illegal), 32'd1);
    check("sll out_result", out_result, 32'd0);
    check("sll out_is_branch", 32'(out_is_branch), 32'd0);
    check("sll alu_ctrl kept", 32'(alu_ctrl), 32'(SUB));
    check("sll alu_a kept", alu_a, 32'd7);
    tick();
    check("sll back to idle", 32'(fsm_state), 32'(ST_IDLE));

    // backpressure in RESP
    out_ready = 1'b0;
    set_op(7'b0110011, 3'b111, 7'b0000000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("bp resp", 32'(out_valid), 32'd1);
    set_op(7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp held valid", 32'(out_valid), 32'd1);
      check("bp held result", out_result, 32'h0F00_0F00);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp alu_a", alu_a, 32'hFF00_FF00);
    end
    out_ready = 1'b1;
    tick();
    check("bp handoff idle", 32'(fsm_state), 32'(ST_IDLE));
    check("bp not accepted", alu_a, 32'hFF00_FF00);
    tick();
    in_valid = 1'b0;
    check("bp second accepted", 32'(fsm_state), 32'(ST_ISSUE));
    check("bp second alu_a", alu_a, 32'd1);
    tick();
    tick();
    check("bp second result", out_result, 32'd3);
    check("bp second valid", 32'(out_valid), 32'd1);
    tick();

    // reset while waiting on the ALU
    set_op(7'b0110011, 3'b000, 7'b0100000, 32'd9, 32'd4, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    check("mid rst wait state", 32'(fsm_state), 32'(ST_WAIT));
    rst = 1'b1;
    #1;
    check("mid rst in_ready", 32'(in_ready), 32'd0);
    tick();
    check("mid rst state", 32'(fsm_state), 32'(ST_IDLE));
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst alu_ctrl", 32'(alu_ctrl), 32'(ADD));
    check("mid rst alu_a", alu_a, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("mid rst no response", 32'(out_valid), 32'd0);
    check("mid rst ready again", 32'(in_ready), 32'd1);

    // 3 legal (one taken branch) + 1 illegal, counted from reset
    run_legal("perf andi", 7'b0010011, 3'b111, 7'b0000000, 32'hF0F0, 32'd0, 32'h0FF0,
              AND, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
    run_legal("perf beq", 7'b1100011, 3'b000, 7'b0000000, 32'd3, 32'd3, 32'd0,
              SUB, 32'd3, 32'd0, 1'b1, 1'b1);
    set_op(7'b1111111, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0);
    tick();
    in_valid = 1'b0;
    check("bad opcode illegal", 32'(out_illegal), 32'd1);
    check("bad opcode valid", 32'(out_valid), 32'd1);
    tick();
    run_legal("perf sw", 7'b0100011, 3'b010, 7'b0000000, 32'h200, 32'd0, 32'h8,
              ADD, 32'h8, 32'h208, 1'b0, 1'b0);
`ifdef ALU_ISSUE_PERF_CNT_EN
    check("perf_issued", perf_issued, 32'd3);
    check("perf_illegal", perf_illegal, 32'd1);
    check("perf_taken", perf_taken, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/response sequencer on the driving side of the ALU interface.
- Accepts one decoded RV32I instruction per valid/ready handshake and maps opcode/funct3/funct7 onto ALU_ctrl_t.
- Drives the operands to the clocked ALU, then captures the ALU result and zero flag after its one-cycle registered latency.
- Returns a writeback value and branch outcome to the downstream stage through a second valid/ready handshake.

Parameters:
- DATA_WIDTH, 32: operand/result width. Must equal RISC_V_DATA_WIDTH.

Ports:
- clk  in  1  single clock. All logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  block can accept an instruction.
- in_opcode  in  7  instr[6:0].
- in_funct3  in  3  instr[14:12].
- in_funct7  in  7  instr[31:25].
- in_rs1  in  DATA_WIDTH  rs1 value (signed).
- in_rs2  in  DATA_WIDTH  rs2 value (signed).
- in_imm  in  DATA_WIDTH  sign-extended immediate.
- alu_a  out  DATA_WIDTH  ALU data_in_A.
- alu_b  out  DATA_WIDTH  ALU data_in_B.
- alu_ctrl  out  ALU_ctrl_t  ALU operation select.
- alu_data_out  in  DATA_WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- out_valid  out  1  response available.
- out_ready  in  1  downstream accepts the response.
- out_result  out  DATA_WIDTH  captured ALU result.
- out_is_branch  out  1  instruction was BEQ or BNE.
- out_taken  out  1  branch taken.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset: state=IDLE; in_ready=0 during reset and 1 the cycle after; out_valid=0; out_result=0; out_is_branch=0; out_taken=0; out_illegal=0; alu_a=0; alu_b=0; alu_ctrl=ADD. Reset mid-operation discards the in-flight op, and no response is emitted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: in_ready=1. On in_valid at the edge, register alu_a/alu_b/alu_ctrl and the flags.
  - Legal encoding -> ISSUE.
  - Illegal encoding -> RESP with out_illegal=1, out_result=0, alu_* unchanged.
- ISSUE: ALU samples alu_* at the end of this cycle. Next state WAIT.
- WAIT: at the edge, capture out_result=alu_data_out. For branches, out_taken = alu_zero (BEQ) or !alu_zero (BNE); otherwise out_taken=0. Next state RESP.
- RESP: out_valid=1, and all out_* are held stable until out_ready. On out_valid&out_ready -> IDLE. No new accept in RESP.
- Latency: accept edge to out_valid = 3 cycles for legal ops, 1 cycle for illegal ops. Max throughput is one op per 4 cycles.
- alu_* outputs hold their last values outside ISSUE/WAIT. in_ready=0 in ISSUE, WAIT and RESP.
- Decode, opcode 0110011 (R-type):
  - funct3 000, funct7 0000000 -> ADD.
  - funct3 000, funct7 0100000 -> SUB.
  - funct3 111, funct7 0 -> AND.
  - funct3 110, funct7 0 -> OR.
  - Everything else illegal.
  - alu_b = rs2.
- Decode, opcode 0010011 (I-type): funct3 000 ADD, 111 AND, 110 OR, others illegal. alu_b = imm. funct7 is ignored.
- Decode, opcode 1100011 (branch): funct3 000 (BEQ) or 001 (BNE) -> SUB with alu_b=rs2 and out_is_branch=1. Other funct3 values illegal.
- Decode, opcodes 0000011 and 0100011 (load/store): ADD with alu_b=imm (address generation).
- Any other opcode is illegal.
- alu_a = rs1 for all legal ops.
- Arithmetic wraps modulo 2^DATA_WIDTH. The block performs no arithmetic itself.
- in_valid while in_ready=0 is ignored; upstream holds the request.

Optional Feature:
- Macro: ALU_ISSUE_PERF_CNT_EN.
- With the macro defined, three extra outputs exist:
  - perf_issued (32): counts legal ops accepted.
  - perf_taken (32): counts responses with out_taken=1 handed off.
  - perf_illegal (32): counts illegal accepts.
- Each counter increments on the respective event edge, wraps at 2^32, and resets to 0 on rst.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- R-type ADD, rs1=5, rs2=-3, ALU model attached, out_ready=1 -> out_valid 3 cycles after accept, out_result=2, out_is_branch=0, out_illegal=0.
- SUB (funct7=0100000), rs1=0x10, rs2=0x20 -> alu_ctrl=SUB during ISSUE, out_result=0xFFFFFFF0. ORI rs1=0xF0, imm=0x0F -> alu_b=0x0F, out_result=0xFF.
- BEQ rs1=rs2=7 -> out_is_branch=1, out_taken=1. BNE rs1=rs2=7 -> out_taken=0. BNE rs1=7, rs2=8 -> out_taken=1.
- opcode 0110011, funct3=001 (SLL) -> out_valid 1 cycle after accept, out_illegal=1, out_result=0, alu_ctrl unchanged.
- Backpressure: out_ready=0 for 5 cycles in RESP -> out_* stable, in_ready=0, a second in_valid is not accepted. out_ready=1 -> IDLE, then the second op is accepted next cycle.
- Assert rst during WAIT -> next cycle state IDLE, out_valid=0, alu_ctrl=ADD, no response. With ALU_ISSUE_PERF_CNT_EN: 3 legal ops + 1 illegal -> perf_issued=3, perf_illegal=1.
